// File: rtl/layer_2_input_packer_pkg.sv
// Shared constants and types for the layer-2 input packer and its position counter.
package layer_2_input_packer_pkg;

  localparam int L2_DATA_WIDTH    = 32;
  localparam int L2_NUM_CH        = 16;
  localparam int L2_IMG_SIZE      = 208;
  localparam int L2_DATA_IN_WIDTH = L2_DATA_WIDTH * L2_NUM_CH;
  localparam int L2_POS_W         = $clog2(L2_IMG_SIZE);

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pos_flags_t;

endpackage

// File: rtl/pixel_position_counter.sv
// Column/row counter for a square feature map; flags describe the current (pre-increment) position.
module pixel_position_counter
  import layer_2_input_packer_pkg::*;
#(
  parameter int IMG_SIZE = L2_IMG_SIZE,
  parameter int POS_W    = L2_POS_W
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_en,
  output pos_flags_t o_flags
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(IMG_SIZE - 1);

  logic [POS_W-1:0] r_col;
  logic [POS_W-1:0] r_row;
  logic             w_last_col;
  logic             w_last_row;

  assign w_last_col = (r_col == LAST_POS);
  assign w_last_row = (r_row == LAST_POS);

  // Advance one pixel per enable, wrapping column into row and row into a new frame.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + POS_W'(1);
      end else begin
        r_col <= r_col + POS_W'(1);
      end
    end
  end

  always_comb begin
    o_flags     = '0;
    o_flags.sof = (r_col == '0) && (r_row == '0);
    o_flags.eol = w_last_col;
    o_flags.eof = w_last_col && w_last_row;
  end

endmodule

// File: rtl/layer_2_input_packer.sv
// Packs NUM_CH channel beats of one pixel into a wide word with ready/valid output and frame flags.
module layer_2_input_packer
  import layer_2_input_packer_pkg::*;
#(
  parameter int DATA_WIDTH    = L2_DATA_WIDTH,
  parameter int NUM_CH        = L2_NUM_CH,
  parameter int DATA_IN_WIDTH = L2_DATA_IN_WIDTH,
  parameter int IMG_SIZE      = L2_IMG_SIZE
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [DATA_IN_WIDTH-1:0] data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     sof_out,
  output logic                     eol_out,
  output logic                     eof_out
);

  localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int               ASM_W   = DATA_WIDTH * (NUM_CH - 1);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]          r_ch_cnt;
  logic [ASM_W-1:0]         r_asm;
  logic [DATA_IN_WIDTH-1:0] r_data_out;
  logic                     r_valid;
  pos_flags_t               r_flags;

  logic                     w_last_ch;
  logic                     w_accept;
  logic                     w_load;
  logic [DATA_IN_WIDTH-1:0] w_word;
  pos_flags_t               w_flags;

  assign w_last_ch = (r_ch_cnt == LAST_CH);
  assign ready_out = !w_last_ch || !r_valid || ready_in;
  assign w_accept  = valid_in && ready_out;
  assign w_load    = w_accept && w_last_ch;
  // The final channel bypasses the assembly register straight into the output word.
  assign w_word    = {data_in, r_asm};

  pixel_position_counter #(
    .IMG_SIZE (IMG_SIZE),
    .POS_W    ($clog2(IMG_SIZE))
  ) u_pos (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_en    (w_load),
    .o_flags (w_flags)
  );

  // Channel assembly plus single-entry output register; drain and load may share an edge.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_ch_cnt   <= '0;
      r_asm      <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_flags    <= '0;
    end else begin
      if (w_accept) begin
        if (w_last_ch) begin
          r_ch_cnt <= '0;
        end else begin
          r_ch_cnt <= r_ch_cnt + CH_W'(1);
          r_asm[DATA_WIDTH*r_ch_cnt +: DATA_WIDTH] <= data_in;
        end
      end
      if (w_load) begin
        r_data_out <= w_word;
        r_flags    <= w_flags;
        r_valid    <= 1'b1;
      end else if (r_valid && ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid;
  assign sof_out   = r_flags.sof;
  assign eol_out   = r_flags.eol;
  assign eof_out   = r_flags.eof;

endmodule

// File: tb/tb_layer_2_input_packer.sv
// Randomised scoreboard bench for layer_2_input_packer (small map size so whole frames fit the run).
module tb_layer_2_input_packer;

  localparam int DW   = 32;
  localparam int NCH  = 16;
  localparam int DIW  = DW * NCH;
  localparam int IMG  = 6;
  localparam int NPIX = IMG * IMG;

  logic           Clk = 1'b0;
  logic           Rst;
  logic [DW-1:0]  data_in;
  logic           valid_in;
  logic           ready_out;
  logic [DIW-1:0] data_out;
  logic           valid_out;
  logic           ready_in;
  logic           sof_out;
  logic           eol_out;
  logic           eof_out;

  always #5 Clk = ~Clk;

  layer_2_input_packer #(
    .DATA_WIDTH    (DW),
    .NUM_CH        (NCH),
    .DATA_IN_WIDTH (DIW),
    .IMG_SIZE      (IMG)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .sof_out   (sof_out),
    .eol_out   (eol_out),
    .eof_out   (eof_out)
  );

  typedef struct {
    logic [DIW-1:0] d;
    logic [2:0]     f;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] beat_q[$];
  int            word_idx  = 0;
  int            checks    = 0;
  int            errors    = 0;
  int            rdy_mode  = 0;
  bit            acc_s     = 1'b0;
  bit            zero_chk  = 1'b0;
  bit            held      = 1'b0;
  bit            exp_vnext = 1'b0;
  logic [DIW-1:0] held_d;
  logic [2:0]     held_f;

  task automatic chk(input string name, input logic [DIW-1:0] act, input logic [DIW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Downstream ready pattern selected by the stimulus thread.
  always @(negedge Clk) begin
    case (rdy_mode)
      0:       ready_in = 1'b1;
      1:       ready_in = 1'b0;
      2:       ready_in = 1'($urandom_range(0, 1));
      3:       ready_in = ~ready_in;
      default: ready_in = 1'b1;
    endcase
  end

  // Monitor + reference model, sampled 1 time unit before each rising edge.
  always @(negedge Clk) begin : mon
    exp_t           e;
    logic [DIW-1:0] w;
    int             pix;
    bit             exp_rdy;
    #4;
    if (zero_chk) begin
      chk("rst_valid", DIW'(valid_out), DIW'(0));
      chk("rst_flags", DIW'({sof_out, eol_out, eof_out}), DIW'(0));
      chk("rst_data", data_out, DIW'(0));
      zero_chk = 1'b0;
    end
    if (!Rst) begin
      beat_q.delete();
      exp_q.delete();
      word_idx  = 0;
      zero_chk  = 1'b1;
      held      = 1'b0;
      exp_vnext = 1'b0;
      acc_s     = 1'b0;
    end else begin
      if (exp_vnext) chk("load_latency", DIW'(valid_out), DIW'(1));
      if (held) begin
        chk("stall_valid", DIW'(valid_out), DIW'(1));
        chk("stall_data", data_out, held_d);
        chk("stall_flags", DIW'({sof_out, eol_out, eof_out}), DIW'(held_f));
      end
      exp_rdy = !((beat_q.size() == NCH - 1) && valid_out && !ready_in);
      chk("ready_out", DIW'(ready_out), DIW'(exp_rdy));
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_word: actual %0h required none", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", data_out, e.d);
          chk("word_flags", DIW'({sof_out, eol_out, eof_out}), DIW'(e.f));
        end
      end
      held   = valid_out && !ready_in;
      held_d = data_out;
      held_f = {sof_out, eol_out, eof_out};
      acc_s  = valid_in && ready_out;
      exp_vnext = 1'b0;
      if (acc_s) begin
        beat_q.push_back(data_in);
        if (beat_q.size() == NCH) begin
          w = '0;
          for (int c = 0; c < NCH; c++) w[DW*c +: DW] = beat_q[c];
          pix = word_idx % NPIX;
          e.d = w;
          e.f = {pix == 0, (pix % IMG) == IMG - 1, pix == NPIX - 1};
          exp_q.push_back(e);
          word_idx++;
          beat_q.delete();
          exp_vnext = 1'b1;
        end
      end
    end
  end

  // Offers one beat after an optional idle gap; returns at the negedge after acceptance.
  task automatic send_beat(input logic [DW-1:0] v, input int gap_max);
    int n;
    n = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b0;
      data_in  = $urandom;
      @(negedge Clk);
    end
    valid_in = 1'b1;
    data_in  = v;
    for (int t = 0; ; t++) begin
      @(negedge Clk);
      if (acc_s) break;
      if (t >= 200) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: actual stalled required accepted within 200 cycles");
        break;
      end
    end
    valid_in = 1'b0;
    data_in  = $urandom;
  endtask

  task automatic send_pixel(input int gap_max);
    for (int c = 0; c < NCH; c++) send_beat($urandom, gap_max);
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
  endtask

  initial begin
    Rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    ready_in = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // Directed first pixel with recognisable channel values.
    for (int c = 0; c < NCH; c++) send_beat(32'h3f800000 + 32'(c), 0);
    #1;
    chk("first_valid", DIW'(valid_out), DIW'(1));
    chk("first_ch0", DIW'(data_out[31:0]), DIW'(32'h3f800000));
    chk("first_ch15", DIW'(data_out[511:480]), DIW'(32'h3f80000f));
    chk("first_sof", DIW'(sof_out), DIW'(1));

    // Stalled downstream while a second pixel arrives, then release.
    rdy_mode = 1;
    fork
      send_pixel(0);
      begin
        repeat (40) @(negedge Clk);
        rdy_mode = 0;
      end
    join

    // Random valid gaps and random downstream ready.
    rdy_mode = 2;
    repeat (3) send_pixel(1);

    // Two full frames plus one word to see the wrap back to sof.
    rdy_mode = 0;
    repeat (2 * NPIX + 1) send_pixel(0);

    // Reset after channel 7 of pixel 5, then a fresh pixel.
    repeat (5) send_pixel(0);
    for (int c = 0; c < 8; c++) send_beat($urandom, 0);
    do_reset();
    send_pixel(0);

    // Continuous input with ready toggling every cycle.
    rdy_mode = 3;
    repeat (6) send_pixel(0);

    rdy_mode = 0;
    for (int t = 0; t < 100 && (exp_q.size() != 0 || valid_out); t++) @(negedge Clk);
    chk("drain_empty", DIW'(exp_q.size()), DIW'(0));
    chk("drain_valid", DIW'(valid_out), DIW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_2_input_packer.md
Name: layer_2_input_packer

Overview:
- Transmit side of the layer-2 feature-map input interface.
- Accepts a channel-interleaved stream of 32-bit float activations, one channel per beat, from the layer-1 output/pool stage.
- Packs NUM_CH channels of one pixel into one DATA_IN_WIDTH word and drives the data_in/valid_in bus shared by all layer_2_featuremap_* instances.
- Adds ready/valid backpressure and frame-position flags for the 208x208 map.

Parameters:
- DATA_WIDTH, 32, width of one activation (IEEE-754 single).
- NUM_CH, 16, input channels packed per output word.
- DATA_IN_WIDTH, 512, packed word width; must equal DATA_WIDTH*NUM_CH.
- IMG_SIZE, 208, feature-map width and height in pixels.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- Rst  input  1  synchronous, active-low reset.
- data_in  input  DATA_WIDTH  one channel value of the current pixel.
- valid_in  input  1  data_in valid.
- ready_out  output  1  packer accepts data_in this cycle.
- data_out  output  DATA_IN_WIDTH  packed pixel; channel c at [DATA_WIDTH*c+DATA_WIDTH-1 : DATA_WIDTH*c].
- valid_out  output  1  data_out holds a complete pixel.
- ready_in  input  1  downstream consumes data_out this cycle.
- sof_out  output  1  with valid_out: pixel (row 0, col 0).
- eol_out  output  1  with valid_out: col IMG_SIZE-1.
- eof_out  output  1  with valid_out: row IMG_SIZE-1, col IMG_SIZE-1.

Behaviour:
- Reset (Rst low at clock edge): valid_out, sof_out, eol_out, eof_out = 0; data_out = 0; channel, column and row counters = 0; any partial assembly is discarded. Reset mid-pixel or mid-frame always restarts at channel 0 of pixel (0,0).
- Accept: a beat transfers when valid_in && ready_out.
- Channel order: channel 0 first. The value is written into the assembly register slot ch_cnt. ch_cnt increments, then wraps from NUM_CH-1 to 0.
- Output stage: one output register.
  - On acceptance of channel NUM_CH-1, the full word (including the final beat) loads into data_out, and valid_out = 1 on the next cycle.
  - Latency from last-channel beat to valid_out is 1 clock.
- Handshake:
  - The output word and its flags are held stable while valid_out && !ready_in.
  - valid_out drops the cycle after valid_out && ready_in, unless a new word loads that same edge.
- ready_out = (ch_cnt != NUM_CH-1) || !valid_out || ready_in.
  - Channels 0..NUM_CH-2 are never stalled.
  - The last channel stalls only while the output register is full and not draining.
  - The path from ready_in to ready_out is combinational.
- Simultaneous drain and load: the old word is consumed and the new word loaded in the same edge, so valid_out stays 1. This gives full throughput of one word per NUM_CH beats.
- Position counters:
  - col/row advance when a word loads into the output register. col wraps at IMG_SIZE-1 and increments row; row wraps at IMG_SIZE-1 to 0.
  - Flags are computed from the pre-increment position and registered with data_out.
  - After eof the next word is a new frame with sof_out = 1.
- valid_in gaps are allowed at any point and leave the partial assembly untouched.
- data_in is ignored while ready_out = 0 or valid_in = 0.

Decomposition:
- Shared package: DATA_WIDTH, per-layer NUM_CH, IMG_SIZE and DATA_IN_WIDTH constants, and a localparam for the counter width, clog2(IMG_SIZE).
- Sub-module: pixel_position_counter (col/row counters with enable and sof/eol/eof generation), parameterised by IMG_SIZE. It is reused by later layer packers.

Test Plan:
- Reset, then 16 beats of 32'h3f800000+c (c=0..15), ready_in=1 → one cycle after beat 15: valid_out=1, data_out[31:0]=32'h3f800000, data_out[511:480]=32'h3f80000f, sof_out=1.
- Hold ready_in=0, then send a second full pixel → beats 0..14 accepted, ready_out=0 on beat 15, data_out unchanged. Raise ready_in → first word drains, second word loads on the same edge, valid_out stays 1.
- Random valid_in gaps (50% duty) across 3 pixels → packed words match a reference model bit-exact, with no lost or duplicated channels.
- Stream a full 208x208 frame → eol_out on words 207, 415, ..., 43263. eof_out only on word 43263. The next word has sof_out=1 (row/col wrapped).
- Assert Rst low after channel 7 of pixel 5 → outputs 0 next cycle. After release, 16 new beats produce a word with sof_out=1, and none of the stale channels appear in it.
- Continuous valid_in with ready_in toggling every cycle → word throughput is never below one per 16 beats while ready_in is high at drain points. data_out and flags are stable throughout every stall.
